// File: rtl/dm_responder.sv
// dm_responder: byte-lane data memory responder with sized, sign/zero-extended loads.
// Optional macro DM_MISALIGN_EN enables word-crossing accesses, which take two beats (IDLE -> SPLIT).
// Without the macro, crossing accesses and odd-offset halves are rejected with an err pulse.
module dm_responder #(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] Data_out,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t        r_state;
    logic          r_ready, r_rvalid, r_err, r_mw;
    logic [31:0]   r_dout, r_lo, r_hi_data;
    logic [3:0]    r_hi_be;
    logic [AW-1:0] r_hi_idx;
    logic [1:0]    r_off;
    logic [2:0]    r_type;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx, w_widx;
    logic [1:0]    w_off;
    logic          w_word, w_half, w_badtype, w_cross, w_split, w_bad, w_acc, w_we;
    logic [3:0]    w_mask, w_wbe;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64;
    logic [31:0]   w_rd, w_single, w_merge, w_wdata;
    logic          w_unused;

    function automatic logic [31:0] f_ext(input logic [31:0] v, input logic [2:0] t);
        return t == 3'b001 ? {{16{v[15]}}, v[15:0]} :
               t == 3'b010 ? {16'h0, v[15:0]} :
               t == 3'b011 ? {{24{v[7]}}, v[7:0]} :
               t == 3'b100 ? {24'h0, v[7:0]} : v;
    endfunction

    assign w_unused  = &{1'b0, Addr_in[31:AW+2]};
    assign w_idx     = Addr_in[AW+1:2];
    assign w_off     = Addr_in[1:0];
    assign w_word    = DMType == 3'b000;
    assign w_half    = DMType == 3'b001 || DMType == 3'b010;
    assign w_badtype = DMType > 3'b100;
    assign w_mask    = w_word ? 4'hF : w_half ? 4'h3 : 4'h1;
    // Lane enables and data spread across a two-word window; the upper half is the next word
    assign w_be8     = {4'h0, w_mask} << w_off;
    assign w_wd64    = {32'h0, Data_in} << {w_off, 3'b000};
    assign w_cross   = (w_word && w_off != 2'd0) || (w_half && w_off == 2'd3);
`ifdef DM_MISALIGN_EN
    assign w_split   = w_cross;
    assign w_bad     = w_badtype;
`else
    assign w_split   = 1'b0;
    assign w_bad     = w_badtype || w_cross || (w_half && w_off[0]);
`endif
    assign w_acc     = rst && req && r_ready;
    assign w_rd      = r_mem[w_idx];
    assign w_single  = w_rd >> {w_off, 3'b000};
    assign w_merge   = 32'({r_mem[r_hi_idx], r_lo} >> {r_off, 3'b000});
    // One write port: the accept beat in IDLE, the high-word beat in SPLIT
    assign w_we      = (r_state == SPLIT) ? r_mw : (w_acc && mem_w && !w_bad);
    assign w_widx    = (r_state == SPLIT) ? r_hi_idx : w_idx;
    assign w_wbe     = (r_state == SPLIT) ? r_hi_be : w_be8[3:0];
    assign w_wdata   = (r_state == SPLIT) ? r_hi_data : w_wd64[31:0];

    assign ready    = r_ready;
    assign rvalid   = r_rvalid;
    assign err      = r_err;
    assign Data_out = r_dout;

    // Byte-lane memory write; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_we)
            for (int b = 0; b < 4; b++)
                if (w_wbe[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end

    // Access FSM: accept, reject, single-beat completion, or split into a second beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= 32'h0;
            r_mw      <= 1'b0;
            r_lo      <= 32'h0;
            r_hi_data <= 32'h0;
            r_hi_be   <= 4'h0;
            r_hi_idx  <= '0;
            r_off     <= 2'd0;
            r_type    <= 3'd0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (r_state == SPLIT) begin
                r_state <= IDLE;
                r_ready <= 1'b1;
                if (!r_mw) begin
                    r_rvalid <= 1'b1;
                    r_dout   <= f_ext(w_merge, r_type);
                end
            end else if (w_acc) begin
                if (w_bad) begin
                    r_err <= 1'b1;
                end else if (w_split) begin
                    r_state   <= SPLIT;
                    r_ready   <= 1'b0;
                    r_mw      <= mem_w;
                    r_lo      <= w_rd;
                    r_hi_data <= w_wd64[63:32];
                    r_hi_be   <= w_be8[7:4];
                    r_hi_idx  <= w_idx + 1'b1;
                    r_off     <= w_off;
                    r_type    <= DMType;
                end else if (!mem_w) begin
                    r_rvalid <= 1'b1;
                    r_dout   <= f_ext(w_single, DMType);
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed scoreboard bench for dm_responder (DEPTH_WORDS 128).
module tb_dm_responder;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, mem_w = 1'b0;
    logic [31:0] Addr_in = 32'h0, Data_in = 32'h0;
    logic [2:0]  DMType = 3'd0;
    logic        ready, rvalid, err;
    logic [31:0] Data_out;

    typedef struct packed {logic e; logic [31:0] d; int due;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, ncnt = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(128)) dut (
        .clk(clk), .rst(rst), .req(req), .mem_w(mem_w), .Addr_in(Addr_in),
        .Data_in(Data_in), .DMType(DMType), .ready(ready), .rvalid(rvalid),
        .Data_out(Data_out), .err(err)
    );

    // Monitor: pops the scoreboard whenever a response pulse appears, or when one is overdue
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (rvalid || err) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got rvalid=%0b err=%0b data=%h, required no pulse", rvalid, err, Data_out);
            end else begin
                e = q.pop_front();
                if (err !== e.e || rvalid !== !e.e || (!e.e && Data_out !== e.d) || ncnt != e.due) begin
                    bad++;
                    $display("FAIL response: got rvalid=%0b err=%0b data=%h at %0d, required err=%0b data=%h at %0d",
                             rvalid, err, Data_out, ncnt, e.e, e.d, e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due < ncnt) begin
            total++;
            bad++;
            e = q.pop_front();
            $display("FAIL missing_response: got nothing, required err=%0b data=%h at %0d", e.e, e.d, e.due);
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %h, required %h", n, a, x);
        end
    endtask

    task automatic acc(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic ex_err, input logic split, input logic [31:0] ex_d);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b, required 1", ready);
        end
        if (ex_err || !w) q.push_back('{ex_err, ex_d, ncnt + 2 + int'(split)});
        mem_w = w; DMType = t; Addr_in = a; Data_in = d; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
    endtask

    task automatic st(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        acc(1'b1, t, a, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [2:0] t, input logic [31:0] a, input logic [31:0] x);
        acc(1'b0, t, a, 32'h0, 1'b0, 1'b0, x);
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (2) begin
            @(posedge clk); #2;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_dout", Data_out, 0);
        rst = 1'b1;
        @(posedge clk); #2;
        st(0, 'h00, 0); st(0, 'h0C, 0); st(0, 'h20, 0); st(0, 'h24, 0);
        st(0, 'h10, 'hDEADBEEF);
        ld(0, 'h10, 'hDEADBEEF);
        st(3, 'h13, 'h80);
        ld(3, 'h13, 'hFFFFFF80);
        ld(4, 'h13, 'h00000080);
        ld(0, 'h10, 'h80ADBEEF);
        ld(1, 'h12, 'hFFFF80AD);
        ld(2, 'h10, 'h0000BEEF);
        ld(0, 'h210, 'h80ADBEEF);
        st(0, 'h1FC, 'h12345678);
        ld(2, 'h1FE, 'h00001234);
        ld(3, 'h1FF, 'h00000012);
        ld(4, 'h1FC, 'h00000078);
        st(3, 'h00, 'h00);
        drain();
        chk("hold_dout", Data_out, 'h78);
        acc(1'b0, 3'd7, 'h10, 0, 1'b1, 1'b0, 0);
        acc(1'b1, 3'd5, 'h10, 0, 1'b1, 1'b0, 0);
        ld(0, 'h10, 'h80ADBEEF);
`ifndef DM_MISALIGN_EN
        acc(1'b0, 3'd0, 'h02, 0, 1'b1, 1'b0, 0);
        chk("ready_after_err", ready, 1);
        acc(1'b1, 3'd0, 'h0E, 'hCAFEF00D, 1'b1, 1'b0, 0);
        acc(1'b1, 3'd1, 'h11, 'h5555, 1'b1, 1'b0, 0);
        acc(1'b0, 3'd1, 'h0F, 0, 1'b1, 1'b0, 0);
        acc(1'b0, 3'd2, 'h11, 0, 1'b1, 1'b0, 0);
        ld(0, 'h0C, 'h00000000);
        ld(0, 'h10, 'h80ADBEEF);
        drain();
        chk("never_split", ready, 1);
`else
        ld(1, 'h11, 'hFFFFADBE);
        drain();
        acc(1'b1, 3'd0, 'h0E, 'h11223344, 1'b0, 1'b1, 0);
        chk("split_ready_low", ready, 0);
        @(posedge clk); #2;
        chk("split_ready_back", ready, 1);
        acc(1'b0, 3'd0, 'h0E, 0, 1'b0, 1'b1, 'h11223344);
        ld(0, 'h0C, 'h33440000);
        ld(0, 'h10, 'h80AD1122);
        acc(1'b1, 3'd1, 'h1FF, 'hABCD, 1'b0, 1'b1, 0);
        ld(4, 'h1FF, 'h000000CD);
        ld(4, 'h00, 'h000000AB);
        acc(1'b0, 3'd1, 'h1FF, 0, 1'b0, 1'b1, 'hFFFFABCD);
        drain();
        acc(1'b1, 3'd0, 'h21, 'h44332211, 1'b0, 1'b1, 0);
        rst = 1'b0;
        #1;
        chk("split_rst_ready", ready, 1);
        chk("split_rst_rvalid", rvalid, 0);
        chk("split_rst_err", err, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        ld(0, 'h20, 'h33221100);
        ld(0, 'h24, 'h00000000);
`endif
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end
endmodule
